// File: rtl/io_port_ctrl.sv
// Memory-mapped IO port block: synchronised and debounced switches/confirm button,
// confirm handshake FSM, LED register. Optional macro IO_LED_READBACK_EN adds LED readback.
module io_port_ctrl #(
  parameter int unsigned DB_CNT_MAX = 200000,
  parameter logic [13:0] SW_ADDR    = 14'h3C70,
  parameter logic [13:0] CFM_ADDR   = 14'h3C80,
  parameter logic [13:0] LED_ADDR   = 14'h3C60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        io_read_i,
  input  logic        io_write_i,
  input  logic [13:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [15:0] rdata_o,
  input  logic [15:0] switch_i,
  input  logic        confirm_btn_i,
  output logic        confirm_o,
  output logic [15:0] led_o
);

  localparam int unsigned SW_W  = 16;
  localparam int unsigned CNT_W = (DB_CNT_MAX > 1) ? $clog2(DB_CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CNT_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_WAIT_ACK
  } state_e;

  logic [SW_W-1:0]  sw_s1_q, sw_s2_q, sw_prev_q, sw_db_q, sw_db_d;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
  logic             btn_s1_q, btn_s2_q, btn_prev_q, btn_db_q, btn_db_d, btn_db_last_q;
  logic [CNT_W-1:0] btn_cnt_q, btn_cnt_d;
  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic [SW_W-1:0]  led_q, led_d;
  logic [SW_W-1:0]  rdata_q, rdata_d;
  logic             ack_c;
  logic             btn_rise_c;
  logic             unused_wdata_c;

  assign ack_c          = io_write_i && (addr_i == CFM_ADDR) && !wdata_i[0];
  assign btn_rise_c     = btn_db_q && !btn_db_last_q;
  assign unused_wdata_c = ^wdata_i[31:16];

  // Switch debouncer: any bit change restarts the whole-vector count
  always_comb begin
    sw_cnt_d = sw_cnt_q;
    sw_db_d  = sw_db_q;
    if (sw_s2_q != sw_prev_q) begin
      sw_cnt_d = '0;
    end else if (sw_cnt_q != CNT_LAST) begin
      sw_cnt_d = sw_cnt_q + CNT_W'(1);
    end else begin
      sw_db_d = sw_s2_q;
    end
  end

  always_comb begin
    btn_cnt_d = btn_cnt_q;
    btn_db_d  = btn_db_q;
    if (btn_s2_q != btn_prev_q) begin
      btn_cnt_d = '0;
    end else if (btn_cnt_q != CNT_LAST) begin
      btn_cnt_d = btn_cnt_q + CNT_W'(1);
    end else begin
      btn_db_d = btn_s2_q;
    end
  end

  // Confirm FSM; an acknowledge always beats a coincident press edge
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    unique case (state_q)
      ST_IDLE: begin
        if (btn_rise_c && !ack_c) begin
          state_d   = ST_HELD;
          pending_d = 1'b1;
        end
      end
      ST_HELD: begin
        if (ack_c) pending_d = 1'b0;
        if (!btn_db_q) state_d = pending_d ? ST_WAIT_ACK : ST_IDLE;
      end
      ST_WAIT_ACK: begin
        if (ack_c) begin
          state_d   = ST_IDLE;
          pending_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    led_d = led_q;
    if (io_write_i && (addr_i == LED_ADDR)) led_d = wdata_i[15:0];
  end

  // Read mux sees pre-write state, so read+write in one cycle returns the old value
  always_comb begin
    rdata_d = rdata_q;
    if (io_read_i) begin
      if (addr_i == SW_ADDR) begin
        rdata_d = sw_db_q;
      end else if (addr_i == CFM_ADDR) begin
        rdata_d = {15'b0, pending_q};
`ifdef IO_LED_READBACK_EN
      end else if (addr_i == LED_ADDR) begin
        rdata_d = led_q;
`endif
      end else begin
        rdata_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q       <= '0;
      sw_s2_q       <= '0;
      sw_prev_q     <= '0;
      sw_cnt_q      <= '0;
      sw_db_q       <= '0;
      btn_s1_q      <= 1'b0;
      btn_s2_q      <= 1'b0;
      btn_prev_q    <= 1'b0;
      btn_cnt_q     <= '0;
      btn_db_q      <= 1'b0;
      btn_db_last_q <= 1'b0;
      state_q       <= ST_IDLE;
      pending_q     <= 1'b0;
      led_q         <= '0;
      rdata_q       <= '0;
    end else begin
      sw_s1_q       <= switch_i;
      sw_s2_q       <= sw_s1_q;
      sw_prev_q     <= sw_s2_q;
      sw_cnt_q      <= sw_cnt_d;
      sw_db_q       <= sw_db_d;
      btn_s1_q      <= confirm_btn_i;
      btn_s2_q      <= btn_s1_q;
      btn_prev_q    <= btn_s2_q;
      btn_cnt_q     <= btn_cnt_d;
      btn_db_q      <= btn_db_d;
      btn_db_last_q <= btn_db_q;
      state_q       <= state_d;
      pending_q     <= pending_d;
      led_q         <= led_d;
      rdata_q       <= rdata_d;
    end
  end

  assign rdata_o   = rdata_q;
  assign confirm_o = pending_q;
  assign led_o     = led_q;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed scoreboard bench for io_port_ctrl (DB_CNT_MAX=4): read data checked by a
// monitor one cycle after each read strobe; confirm/LED levels checked directly.
module tb_io_port_ctrl;

  localparam int unsigned DB    = 4;
  localparam logic [13:0] SW_A  = 14'h3C70;
  localparam logic [13:0] CFM_A = 14'h3C80;
  localparam logic [13:0] LED_A = 14'h3C60;
  localparam logic [13:0] OTH_A = 14'h3C90;
`ifdef IO_LED_READBACK_EN
  localparam logic [15:0] LED_RB = 16'hBEEF;
`else
  localparam logic [15:0] LED_RB = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_read = 1'b0;
  logic        io_write = 1'b0;
  logic [13:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [15:0] rdata;
  logic [15:0] sw = 16'hFFFF;
  logic        btn = 1'b0;
  logic        cfm;
  logic [15:0] led;

  logic [15:0] exp_val_q[$];
  string       exp_name_q[$];
  logic        rd_due = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  io_port_ctrl #(.DB_CNT_MAX(DB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .io_read_i     (io_read),
    .io_write_i    (io_write),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .rdata_o       (rdata),
    .switch_i      (sw),
    .confirm_btn_i (btn),
    .confirm_o     (cfm),
    .led_o         (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: read data appears one cycle after the strobe
  always @(posedge clk) rd_due <= io_read && rst_n;

  always @(negedge clk) begin
    if (rd_due) begin
      if (exp_val_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rd_unexpected: got %h expected no read", rdata);
      end else begin
        check(exp_name_q.pop_front(), rdata, exp_val_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [13:0] a, input logic [15:0] exp, input string name);
    addr = a;
    io_read = 1'b1;
    exp_val_q.push_back(exp);
    exp_name_q.push_back(name);
    @(negedge clk);
    io_read = 1'b0;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    io_write = 1'b1;
    @(negedge clk);
    io_write = 1'b0;
  endtask

  task automatic rdwr(input logic [13:0] a, input logic [31:0] d, input logic [15:0] exp,
                      input string name);
    addr = a;
    wdata = d;
    io_read = 1'b1;
    io_write = 1'b1;
    exp_val_q.push_back(exp);
    exp_name_q.push_back(name);
    @(negedge clk);
    io_read = 1'b0;
    io_write = 1'b0;
  endtask

  task automatic press(input int hold, input int rel);
    btn = 1'b1;
    cyc(hold);
    btn = 1'b0;
    cyc(rel);
  endtask

  initial begin
    // Reset with switches all high
    cyc(3);
    check("rst_led", led, 16'h0);
    check("rst_rdata", rdata, 16'h0);
    check("rst_cfm", {15'b0, cfm}, 16'h0);
    sw = 16'hA5A5;
    rst_n = 1'b1;
    rd(SW_A, 16'h0000, "sw_after_rst");

    // Switch debounce
    cyc(8);
    rd(SW_A, 16'hA5A5, "sw_stable");
    sw = 16'h0000;
    cyc(2);
    sw = 16'hA5A5;
    rd(SW_A, 16'hA5A5, "sw_in_glitch");
    cyc(8);
    rd(SW_A, 16'hA5A5, "sw_after_glitch");
    sw = 16'h5A5A;
    cyc(8);
    rd(SW_A, 16'h5A5A, "sw_new_value");

    // Basic confirm handshake
    press(10, 10);
    check("cfm_pending", {15'b0, cfm}, 16'h1);
    rd(CFM_A, 16'h0001, "cfm_rd_pending");
    wr(CFM_A, 32'h0);
    check("cfm_ack", {15'b0, cfm}, 16'h0);
    rd(CFM_A, 16'h0000, "cfm_rd_cleared");

    // Ignored ack (bit0=1) and second press while pending
    press(10, 10);
    wr(CFM_A, 32'h1);
    check("cfm_ack_bit1_ignored", {15'b0, cfm}, 16'h1);
    wr(SW_A, 32'h0);
    check("cfm_sw_write_ignored", {15'b0, cfm}, 16'h1);
    press(10, 10);
    check("cfm_second_press", {15'b0, cfm}, 16'h1);
    wr(CFM_A, 32'h0);
    check("cfm_single_ack", {15'b0, cfm}, 16'h0);
    cyc(5);
    check("cfm_stays_clear", {15'b0, cfm}, 16'h0);

    // Acknowledge while still held, then release returns to idle
    btn = 1'b1;
    cyc(10);
    check("held_pending", {15'b0, cfm}, 16'h1);
    wr(CFM_A, 32'h0);
    check("held_ack", {15'b0, cfm}, 16'h0);
    cyc(3);
    check("held_still_clear", {15'b0, cfm}, 16'h0);
    btn = 1'b0;
    cyc(10);
    check("held_release", {15'b0, cfm}, 16'h0);
    press(10, 10);
    check("held_repress", {15'b0, cfm}, 16'h1);
    wr(CFM_A, 32'h0);
    check("held_repress_ack", {15'b0, cfm}, 16'h0);

    // Acknowledge held across the press edge: ack wins on the coincident cycle
    btn = 1'b1;
    addr = CFM_A;
    wdata = 32'h0;
    io_write = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("coinc_cyc%0d", i), {15'b0, cfm}, 16'h0);
    end
    io_write = 1'b0;
    cyc(3);
    check("coinc_after", {15'b0, cfm}, 16'h0);
    btn = 1'b0;
    cyc(10);
    check("coinc_release", {15'b0, cfm}, 16'h0);

    // LED register
    wr(LED_A, 32'h1234_BEEF);
    check("led_write", led, 16'hBEEF);
    wr(OTH_A, 32'hFFFF_0000);
    check("led_other_addr", led, 16'hBEEF);
    wr(SW_A, 32'h0000_1111);
    check("led_sw_addr", led, 16'hBEEF);
    rd(LED_A, LED_RB, "led_readback");
    rd(OTH_A, 16'h0000, "rd_other_addr");
    rd(SW_A, 16'h5A5A, "rd_sw_again");
    cyc(3);
    check("rd_hold", rdata, 16'h5A5A);

    // Same-cycle read and write return pre-write values
    press(10, 10);
    rdwr(CFM_A, 32'h0, 16'h0001, "rdwr_cfm_prewrite");
    check("rdwr_cfm_cleared", {15'b0, cfm}, 16'h0);
    rdwr(LED_A, 32'h0000_1111, LED_RB, "rdwr_led_prewrite");
    check("rdwr_led_written", led, 16'h1111);
    wr(LED_A, 32'h0000_BEEF);

    // Asynchronous reset mid-operation, button held through it
    press(10, 10);
    check("pre_rst_cfm", {15'b0, cfm}, 16'h1);
    check("pre_rst_led", led, 16'hBEEF);
    btn = 1'b1;
    cyc(2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led", led, 16'h0);
    check("async_rst_cfm", {15'b0, cfm}, 16'h0);
    check("async_rst_rdata", rdata, 16'h0);
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("rst_debounce_cyc%0d", i), {15'b0, cfm}, 16'h0);
    end
    cyc(6);
    check("rst_press_debounced", {15'b0, cfm}, 16'h1);
    check("rst_led_stays", led, 16'h0);
    btn = 1'b0;

    cyc(3);
    n_vec++;
    if (exp_val_q.size() != 0) begin
      n_err++;
      $display("FAIL rd_queue_drain: got %0d pending expected 0", exp_val_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
